// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Imported by regfile_init_fsm and regfile_mp.
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;

  function automatic int rf_aw(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_init_fsm.sv
// Post-reset clear sequencer: walks every entry once, writing zero.
// busy stays high from reset until the last entry has been cleared.
module regfile_init_fsm
  import regfile_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  output logic                     clr_we,
  output logic [$clog2(NREG)-1:0]  clr_addr
);

  localparam int AW = rf_aw(NREG);

  rf_state_e      state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_INIT) begin
      if (cnt_q == AW'(NREG - 1)) state_d = RF_READY;
      else cnt_d = cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == RF_INIT);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and post-reset clear.
// Optional macro REGFILE_DEBUG_EN adds a raw debug read port and write counter.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NWR-1:0]                wen,
  input  logic [NWR*$clog2(NREG)-1:0]   waddr,
  input  logic [NWR*XLEN-1:0]           wdata,
  input  logic [NRD*$clog2(NREG)-1:0]   raddr,
  output logic [NRD*XLEN-1:0]           rdata,
`ifdef REGFILE_DEBUG_EN
  input  logic [$clog2(NREG)-1:0]       debug_raddr,
  output logic [XLEN-1:0]               debug_reg,
  output logic [31:0]                   debug_wcnt,
`endif
  output logic                          init_busy
);

  localparam int AW = rf_aw(NREG);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic [NWR-1:0]  wr_ok;
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  regfile_init_fsm #(
    .NREG (NREG)
  ) u_init (
    .clk      (clk),
    .rst      (rst),
    .busy     (init_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A write commits only in READY and never to a hardwired zero entry.
  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < NWR; i++) begin
      wr_ok[i] = wen[i] && !init_busy &&
                 (ZERO_REG == 0 || waddr[i*AW +: AW] != '0);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok[i]) mem_d[waddr[i*AW +: AW]] = wdata[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    assign ra = raddr[j*AW +: AW];
    always_comb begin
      rd = mem_q[ra];
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok[i] && waddr[i*AW +: AW] == ra) rd = wdata[i*XLEN +: XLEN];
      end
      if (init_busy || (ZERO_REG != 0 && ra == '0)) rd = '0;
    end
    assign rdata[j*XLEN +: XLEN] = rd;
  end

`ifdef REGFILE_DEBUG_EN
  logic [31:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    for (int i = 0; i < NWR; i++) begin
      if (wr_ok[i]) wcnt_d = wcnt_d + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wcnt_q <= '0;
    else     wcnt_q <= wcnt_d;
  end

  assign debug_reg  = mem_q[debug_raddr];
  assign debug_wcnt = wcnt_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp (2 write / 2 read ports) against an array model.
// Debug port checks are included when REGFILE_DEBUG_EN is defined.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NWR-1:0]       wen;
  logic [NWR*AW-1:0]    waddr;
  logic [NWR*XLEN-1:0]  wdata;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic                 init_busy;
`ifdef REGFILE_DEBUG_EN
  logic [AW-1:0]        debug_raddr;
  logic [XLEN-1:0]      debug_reg;
  logic [31:0]          debug_wcnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [XLEN-1:0] mem_m [NREG];
  int              init_left;
  logic [31:0]     wcnt_m;

  regfile_mp #(
    .XLEN     (XLEN),
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr       (raddr),
    .rdata       (rdata),
`ifdef REGFILE_DEBUG_EN
    .debug_raddr (debug_raddr),
    .debug_reg   (debug_reg),
    .debug_wcnt  (debug_wcnt),
`endif
    .init_busy   (init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra);
    logic [XLEN-1:0] v;
    if (init_left != 0 || ra == 0) return '0;
    v = mem_m[ra];
    for (int i = 0; i < NWR; i++) begin
      if (wen[i] && waddr[i*AW +: AW] == ra) v = wdata[i*XLEN +: XLEN];
    end
    return v;
  endfunction

  task automatic clk_step();
    @(posedge clk);
    if (rst) begin
      init_left = NREG;
      wcnt_m    = '0;
      for (int k = 0; k < NREG; k++) mem_m[k] = '0;
    end else if (init_left > 0) begin
      init_left--;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wen[i] && waddr[i*AW +: AW] != 0) begin
          mem_m[waddr[i*AW +: AW]] = wdata[i*XLEN +: XLEN];
          wcnt_m++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; raddr = '0;
  endtask

  task automatic check_reads(input string tag);
    #1;
    chk({tag, "_rd0"}, rdata[0 +: XLEN], exp_rd(raddr[0 +: AW]));
    chk({tag, "_rd1"}, rdata[XLEN +: XLEN], exp_rd(raddr[AW +: AW]));
    chk({tag, "_busy"}, {31'd0, init_busy}, {31'd0, init_left != 0});
  endtask

  // Release reset and watch the clear run for exactly NREG cycles.
  task automatic release_and_clear(input string tag);
    rst = 1'b0;
    for (int c = 0; c < NREG; c++) begin
      wen   = 2'($urandom);
      waddr = 10'($urandom);
      wdata = {$urandom, $urandom};
      raddr = 10'($urandom);
      #1;
      chk({tag, "_busy_hi"}, {31'd0, init_busy}, 32'd1);
      chk({tag, "_rd_init"}, rdata[0 +: XLEN], 32'd0);
      clk_step();
    end
    idle();
    #1;
    chk({tag, "_busy_lo"}, {31'd0, init_busy}, 32'd0);
    for (int r = 0; r < NREG; r += 2) begin
      raddr = {5'(r + 1), 5'(r)};
      #1;
      chk({tag, "_clr0"}, rdata[0 +: XLEN], 32'd0);
      chk({tag, "_clr1"}, rdata[XLEN +: XLEN], 32'd0);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    init_left = NREG;
    wcnt_m    = '0;
    for (int k = 0; k < NREG; k++) mem_m[k] = '0;
`ifdef REGFILE_DEBUG_EN
    debug_raddr = '0;
`endif
    @(negedge clk);

    repeat (3) begin
      #1 chk("rst_busy", {31'd0, init_busy}, 32'd1);
      clk_step();
    end
    release_and_clear("init");

    // x5 write then read next cycle
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF};
    check_reads("w5");
    clk_step();
    idle(); raddr = {5'd0, 5'd5};
    #1 chk("x5_read", rdata[0 +: XLEN], 32'hDEADBEEF);
    check_reads("x5");

    // write to x0 is discarded
    wen = 2'b01; waddr = '0; wdata = {32'd0, 32'h1234};
    clk_step();
    idle();
    #1 chk("x0_read", rdata[0 +: XLEN], 32'd0);

    // same-cycle bypass
    wen = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'hA5A5A5A5};
    raddr = {5'd7, 5'd0};
    #1 chk("byp7", rdata[XLEN +: XLEN], 32'hA5A5A5A5);
    check_reads("byp");
    clk_step();

    // both ports write x3: port 1 wins
    wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11};
    raddr = {5'd3, 5'd3};
    #1 chk("conf_byp", rdata[0 +: XLEN], 32'h22);
    clk_step();
    idle(); raddr = {5'd0, 5'd3};
    #1 chk("conf_store", rdata[0 +: XLEN], 32'h22);

    for (int n = 0; n < 400; n++) begin
      wen   = 2'($urandom);
      waddr = ($urandom_range(0, 1) == 0) ? {2{2'b0, 3'($urandom)}} & 10'($urandom | 32'h0E7)
                                          : 10'($urandom);
      wdata = {$urandom, $urandom};
      raddr = ($urandom_range(0, 1) == 0) ? waddr : 10'($urandom);
`ifdef REGFILE_DEBUG_EN
      debug_raddr = 5'($urandom);
      #1;
      chk("dbg_reg", debug_reg, mem_m[debug_raddr]);
      chk("dbg_cnt", debug_wcnt, wcnt_m);
`endif
      check_reads("rnd");
      clk_step();
    end
    idle();

    // reset pulse in the middle of the clear restarts it
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    repeat (10) clk_step();
    #1 chk("mid_busy", {31'd0, init_busy}, 32'd1);
    rst = 1'b1;
    clk_step();
    release_and_clear("midrst");

`ifdef REGFILE_DEBUG_EN
    chk("dbg_cnt0", debug_wcnt, 32'd0);
    wen = 2'b01;
    waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hCAFE0005}; clk_step();
    waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'h00000BAD}; clk_step();
    waddr = {5'd0, 5'd6}; wdata = {32'd0, 32'hCAFE0006}; clk_step();
    waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'hCAFE0007}; clk_step();
    idle();
    debug_raddr = 5'd5;
    #1;
    chk("dbg_wcnt3", debug_wcnt, 32'd3);
    chk("dbg_x5", debug_reg, 32'hCAFE0005);
    debug_raddr = 5'd0;
    #1 chk("dbg_x0", debug_reg, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
